// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side update bundle for branch_predictor.
// master = core (drives fetch/update), slave = predictor.
interface branch_predictor_if #(
    parameter int XLEN     = 32,
    parameter int GHR_BITS = 6
);
    logic [XLEN-1:0]     fetch_pc;
    logic                pred_taken;
    logic [XLEN-1:0]     pred_target;
    logic [GHR_BITS-1:0] pred_ghr;

    logic                upd_valid;
    logic [XLEN-1:0]     upd_pc;
    logic                upd_taken;
    logic [XLEN-1:0]     upd_target;
    logic                upd_pred_taken;
    logic [XLEN-1:0]     upd_pred_target;
    logic [GHR_BITS-1:0] upd_ghr;

    logic                mispredict;
    logic [31:0]         branch_count;
    logic [31:0]         mispredict_count;

    modport master (
        output fetch_pc,
        output upd_valid, upd_pc, upd_taken, upd_target,
        output upd_pred_taken, upd_pred_target, upd_ghr,
        input  pred_taken, pred_target, pred_ghr,
        input  mispredict, branch_count, mispredict_count
    );

    modport slave (
        input  fetch_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        input  upd_pred_taken, upd_pred_target, upd_ghr,
        output pred_taken, pred_target, pred_ghr,
        output mispredict, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal/gshare branch predictor: 2-bit counter BHT plus tagged direct-mapped BTB.
// Define BP_GSHARE_EN to XOR global history into the BHT index (gshare mode).
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int GHR_BITS = 6
) (
    input  logic              clk,
    input  logic              reset,
    branch_predictor_if.slave bp
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    typedef logic [1:0] ctr_t;
    localparam ctr_t CTR_WEAK_NT = 2'b01;

    ctr_t             r_bht        [ENTRIES];
    logic [ENTRIES-1:0] r_btb_valid;
    logic [TAG_W-1:0] r_btb_tag    [ENTRIES];
    logic [XLEN-1:0]  r_btb_target [ENTRIES];
    logic [31:0]      r_branch_count;
    logic [31:0]      r_mispredict_count;

    logic [IDX-1:0]      w_fetch_idx;
    logic [IDX-1:0]      w_fetch_bidx;
    logic [TAG_W-1:0]    w_fetch_tag;
    logic [IDX-1:0]      w_upd_idx;
    logic [IDX-1:0]      w_upd_bidx;
    logic [TAG_W-1:0]    w_upd_tag;
    logic                w_hit;
    logic                w_pred_taken;
    logic [XLEN-1:0]     w_pred_target;
    logic [GHR_BITS-1:0] w_pred_ghr;
    logic                w_mispredict;
    ctr_t                w_next_ctr;
    logic                w_update;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        if (taken && c != 2'b11)
            n = c + 2'b01;
        else if (!taken && c != 2'b00)
            n = c - 2'b01;
        return n;
    endfunction

    assign w_fetch_idx = bp.fetch_pc[IDX+1:2];
    assign w_fetch_tag = bp.fetch_pc[XLEN-1:IDX+2];
    assign w_upd_idx   = bp.upd_pc[IDX+1:2];
    assign w_upd_tag   = bp.upd_pc[XLEN-1:IDX+2];

    // Reset wins over a same-cycle update: the pending resolve is dropped.
    assign w_update = bp.upd_valid && !reset;

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] r_ghr;

    always_ff @(posedge clk) begin
        if (reset)
            r_ghr <= '0;
        else if (bp.upd_valid)
            r_ghr <= {r_ghr[GHR_BITS-2:0], bp.upd_taken};
    end

    // Updates use the history captured at fetch, not the live register.
    assign w_fetch_bidx = w_fetch_idx ^ IDX'(r_ghr);
    assign w_upd_bidx   = w_upd_idx ^ IDX'(bp.upd_ghr);
    assign w_pred_ghr   = r_ghr;
`else
    assign w_fetch_bidx = w_fetch_idx;
    assign w_upd_bidx   = w_upd_idx;
    assign w_pred_ghr   = '0;
`endif

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_hit         = 1'b0;
        w_pred_taken  = 1'b0;
        w_pred_target = bp.fetch_pc + XLEN'(4);
        if (r_btb_valid[w_fetch_idx] && r_btb_tag[w_fetch_idx] == w_fetch_tag)
            w_hit = 1'b1;
        if (w_hit && r_bht[w_fetch_bidx][1]) begin
            w_pred_taken  = 1'b1;
            w_pred_target = r_btb_target[w_fetch_idx];
        end
    end

    always_comb begin
        w_mispredict = 1'b0;
        if (w_update) begin
            if (bp.upd_taken != bp.upd_pred_taken)
                w_mispredict = 1'b1;
            else if (bp.upd_taken && bp.upd_target != bp.upd_pred_target)
                w_mispredict = 1'b1;
        end
    end

    assign w_next_ctr = ctr_next(r_bht[w_upd_bidx], bp.upd_taken);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                r_bht[i] <= CTR_WEAK_NT;
        end else if (bp.upd_valid) begin
            r_bht[w_upd_bidx] <= w_next_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_btb_valid <= '0;
        else if (bp.upd_valid && bp.upd_taken)
            r_btb_valid[w_upd_idx] <= 1'b1;
    end

    // NOTE: tag/target storage has no reset; the valid bits alone make stale contents harmless.
    always_ff @(posedge clk) begin
        if (w_update && bp.upd_taken) begin
            r_btb_tag[w_upd_idx]    <= w_upd_tag;
            r_btb_target[w_upd_idx] <= bp.upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (bp.upd_valid)
                r_branch_count <= r_branch_count + 32'd1;
            if (w_mispredict)
                r_mispredict_count <= r_mispredict_count + 32'd1;
        end
    end

    assign bp.pred_taken       = w_pred_taken;
    assign bp.pred_target      = w_pred_target;
    assign bp.pred_ghr         = w_pred_ghr;
    assign bp.mispredict       = w_mispredict;
    assign bp.branch_count     = r_branch_count;
    assign bp.mispredict_count = r_mispredict_count;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (bimodal by default,
// gshare expectations selected when BP_GSHARE_EN is defined).
module tb_branch_predictor;
    localparam int XLEN     = 32;
    localparam int ENTRIES  = 64;
    localparam int GHR_BITS = 6;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    branch_predictor_if #(.XLEN(XLEN), .GHR_BITS(GHR_BITS)) bp_if ();

    branch_predictor #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .GHR_BITS(GHR_BITS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bp   (bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                           input logic ptaken, input logic [31:0] ptarget,
                           input logic [GHR_BITS-1:0] ghr);
        bp_if.upd_valid       = 1'b1;
        bp_if.upd_pc          = pc;
        bp_if.upd_taken       = taken;
        bp_if.upd_target      = target;
        bp_if.upd_pred_taken  = ptaken;
        bp_if.upd_pred_target = ptarget;
        bp_if.upd_ghr         = ghr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic                p_taken;
        logic [31:0]         p_target;
        logic [GHR_BITS-1:0] p_ghr;
        int                  late_misp;

        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bp_if.fetch_pc = 32'h100;
        bp_if.upd_valid = 1'b0;
        bp_if.upd_pc = '0;
        bp_if.upd_taken = 1'b0;
        bp_if.upd_target = '0;
        bp_if.upd_pred_taken = 1'b0;
        bp_if.upd_pred_target = '0;
        bp_if.upd_ghr = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_taken",  32'(bp_if.pred_taken), 32'd0);
        check("rst_target", bp_if.pred_target, 32'h104);
        check("rst_ghr",    32'(bp_if.pred_ghr), 32'd0);
        check("rst_bcnt",   bp_if.branch_count, 32'd0);
        check("rst_mcnt",   bp_if.mispredict_count, 32'd0);

        // Training: first taken update; same-cycle lookup still sees old state
        set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, '0);
        #1;
        check("train_misp_comb", 32'(bp_if.mispredict), 32'd1);
        check("train_no_wthru",  32'(bp_if.pred_taken), 32'd0);
        step();
        bp_if.upd_valid = 1'b0;
        #1;
        check("train_taken",  32'(bp_if.pred_taken), 32'd1);
        check("train_target", bp_if.pred_target, 32'h200);
        check("train_bcnt",   bp_if.branch_count, 32'd1);

        // Saturation (10 -> 11 -> 11 -> 11), then hysteresis on not-taken
        for (int i = 0; i < 3; i++) begin
            set_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, '0);
            step();
        end
        set_upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200, '0);
        #1;
        check("hyst_misp_comb", 32'(bp_if.mispredict), 32'd1);
        step();
        bp_if.upd_valid = 1'b0;
        #1;
        check("hyst_taken_after1", 32'(bp_if.pred_taken), 32'd1);
        set_upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200, '0);
        step();
        bp_if.upd_valid = 1'b0;
        #1;
        check("hyst_taken_after2",  32'(bp_if.pred_taken), 32'd0);
        check("hyst_target_after2", bp_if.pred_target, 32'h104);
        check("hyst_bcnt", bp_if.branch_count, 32'd6);
        check("hyst_mcnt", bp_if.mispredict_count, 32'd3);

        // Aliasing: 0x200 shares index 0 with 0x100 but has a different tag
        set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, '0);
        step();
        bp_if.upd_valid = 1'b0;
        #1;
        check("alias_own_taken", 32'(bp_if.pred_taken), 32'd1);
        bp_if.fetch_pc = 32'h200;
        #1;
        check("alias_taken",  32'(bp_if.pred_taken), 32'd0);
        check("alias_target", bp_if.pred_target, 32'h204);

        // Top of address space wraps to 0; last index entry
        bp_if.fetch_pc = 32'hFFFF_FFFC;
        #1;
        check("wrap_target", bp_if.pred_target, 32'h0);
        set_upd(32'h0FC, 1'b1, 32'h40, 1'b0, 32'h100, '0);
        step();
        bp_if.upd_valid = 1'b0;
        bp_if.fetch_pc = 32'h0FC;
        #1;
        check("lastidx_taken",  32'(bp_if.pred_taken), 32'd1);
        check("lastidx_target", bp_if.pred_target, 32'h40);
        bp_if.fetch_pc = 32'hFFFF_FFFC;
        #1;
        check("lastidx_alias_taken", 32'(bp_if.pred_taken), 32'd0);
        check("lastidx_bcnt", bp_if.branch_count, 32'd8);
        check("lastidx_mcnt", bp_if.mispredict_count, 32'd5);

        // Mispredict equation corner cases (no clock edge taken)
        set_upd(32'h300, 1'b0, 32'h999, 1'b0, 32'h123, '0);
        #1;
        check("nt_target_ignored", 32'(bp_if.mispredict), 32'd0);
        set_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, '0);
        #1;
        check("taken_match", 32'(bp_if.mispredict), 32'd0);
        bp_if.upd_valid = 1'b0;
        #1;
        check("idle_misp", 32'(bp_if.mispredict), 32'd0);

        // Reset with a pending update: update is discarded
        reset = 1'b1;
        set_upd(32'h114, 1'b1, 32'h500, 1'b0, 32'h0, '0);
        #1;
        check("rst_misp_gated", 32'(bp_if.mispredict), 32'd0);
        step();
        reset = 1'b0;
        bp_if.upd_valid = 1'b0;
        bp_if.fetch_pc = 32'h114;
        #1;
        check("rstupd_taken",  32'(bp_if.pred_taken), 32'd0);
        check("rstupd_target", bp_if.pred_target, 32'h118);
        check("rstupd_bcnt",   bp_if.branch_count, 32'd0);
        check("rstupd_mcnt",   bp_if.mispredict_count, 32'd0);
        bp_if.fetch_pc = 32'h100;
        #1;
        check("rst_clears_btb", 32'(bp_if.pred_taken), 32'd0);

        // Misprediction accounting: right direction, wrong target
        set_upd(32'h100, 1'b1, 32'h300, 1'b1, 32'h200, '0);
        #1;
        check("mp_comb", 32'(bp_if.mispredict), 32'd1);
        step();
        bp_if.upd_valid = 1'b0;
        #1;
        check("mp_mcnt",   bp_if.mispredict_count, 32'd1);
        check("mp_bcnt",   bp_if.branch_count, 32'd1);
        check("mp_taken",  32'(bp_if.pred_taken), 32'd1);
        check("mp_target", bp_if.pred_target, 32'h300);

        // Alternating T/N branch at 0x100 from a fresh reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        bp_if.fetch_pc = 32'h100;
        late_misp = 0;
        for (int i = 0; i < 24; i++) begin
            #1;
            p_taken  = bp_if.pred_taken;
            p_target = bp_if.pred_target;
            p_ghr    = bp_if.pred_ghr;
            set_upd(32'h100, (i % 2) == 0, 32'h200, p_taken, p_target, p_ghr);
            #1;
            if (i >= 8 && bp_if.mispredict)
                late_misp++;
            step();
        end
        bp_if.upd_valid = 1'b0;
        #1;
        check("alt_bcnt", bp_if.branch_count, 32'd24);
`ifdef BP_GSHARE_EN
        check("alt_late_misp", 32'(late_misp), 32'd0);
        check("alt_mcnt",      bp_if.mispredict_count, 32'd4);
        check("alt_ghr",       32'(bp_if.pred_ghr), 32'h2A);
`else
        check("alt_late_misp_ge8", 32'(late_misp >= 8), 32'd1);
        check("alt_late_misp",     32'(late_misp), 32'd16);
        check("alt_mcnt",          bp_if.mispredict_count, 32'd24);
        check("alt_ghr",           32'(bp_if.pred_ghr), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

- Dynamic branch predictor for the fetch stage of the RISC-V core. It is the parametrised successor to the hard-wired resolve-in-execute branch logic.
- Holds a direct-mapped table of 2-bit saturating counters (BHT) and a tagged branch target buffer (BTB).
- Returns a same-cycle taken/target prediction for the fetch PC. Learns from resolved branches reported back by the execute unit.
- Keeps branch and misprediction statistics next to the core's `cycle_count`.

## Interface
Parameters:
- `XLEN`, 32, address/data width.
- `ENTRIES`, 64, BHT and BTB depth. Power of two, ≥ 4. `IDX = $clog2(ENTRIES)`.
- `GHR_BITS`, 6, global history length. Must be ≤ `IDX`. Used only with `BP_GSHARE_EN`.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `fetch_pc` in XLEN: PC being fetched. Bits [1:0] are ignored.
- `pred_taken` out 1: predicted taken.
- `pred_target` out XLEN: predicted next PC.
- `pred_ghr` out GHR_BITS: history snapshot used for this prediction.
- `upd_valid` in 1: a conditional branch resolved this cycle.
- `upd_pc` in XLEN: PC of the resolved branch.
- `upd_taken` in 1: actual direction.
- `upd_target` in XLEN: actual taken target.
- `upd_pred_taken` in 1: prediction that was issued for this branch.
- `upd_pred_target` in XLEN: target that was issued for this branch.
- `upd_ghr` in GHR_BITS: `pred_ghr` value captured at fetch of this branch.
- `mispredict` out 1: combinational; the current update was mispredicted.
- `branch_count` out 32: resolved branches since reset.
- `mispredict_count` out 32: mispredictions since reset.

## Operation
Field split:
- Index: `pc[IDX+1:2]`.
- Tag: `pc[XLEN-1:IDX+2]`.
- BHT index: the index, XOR'd with the zero-extended history when `BP_GSHARE_EN` is defined.

Lookup (combinational, asynchronous table read):
- `hit = btb_valid[idx] && btb_tag[idx] == tag(fetch_pc)`.
- `pred_taken = hit && bht[bidx][1]`.
- `pred_target = pred_taken ? btb_target[idx] : fetch_pc + 4`, computed modulo 2^XLEN.

Update (on `clk` when `upd_valid` is high), with the BHT indexed from `upd_pc` and `upd_ghr`:
- Counter increments on taken and decrements on not-taken. It saturates at 2'b11 and 2'b00.
- On taken: the BTB entry at idx(upd_pc) is overwritten with valid=1, the tag and `upd_target`.
- On not-taken: the BTB is left unchanged.

Misprediction:
- `mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target))`.
- `branch_count` increments on every `upd_valid`.
- `mispredict_count` increments when `mispredict` is high.
- Both counters wrap modulo 2^32.

Reset:
- All BHT counters go to 2'b01 (weakly not-taken) and all BTB valid bits clear. Tag and target contents are don't-care.
- History clears to 0 and both statistics counters clear to 0.
- Reset values of the outputs: `pred_taken` = 0, `pred_target` = `fetch_pc + 4`, `pred_ghr` = 0, `mispredict` = 0, both counts = 0.
- Reset overrides `upd_valid` in the same cycle.

## Timing
- Prediction has zero-cycle latency: combinational from `fetch_pc` and the table state.
- An update becomes visible to lookups on the cycle after the edge that writes it.
- Same-cycle lookup and update of the same index: the lookup sees the pre-update (old) contents. There is no write-through.
- History shift (`BP_GSHARE_EN` only): `ghr <= {ghr[GHR_BITS-2:0], upd_taken}` on each `upd_valid`. It is not corrected on mispredict; the core supplies `upd_ghr`.
- Only one update per cycle. Back-to-back updates on consecutive cycles are fully supported.
- Reset asserted mid-operation takes effect at the next edge. Any pending update in that cycle is discarded.

## Configuration
- `BP_GSHARE_EN` defined (gshare):
  - BHT index = `pc[IDX+1:2] ^ {{(IDX-GHR_BITS){1'b0}}, ghr}`.
  - `pred_ghr` = `ghr`.
  - Updates index the BHT with `upd_ghr`.
- `BP_GSHARE_EN` not defined (bimodal):
  - The BHT is indexed by `pc[IDX+1:2]` only.
  - No history register is built, `pred_ghr` is tied to 0 and `upd_ghr` is ignored.
  - The BTB and statistics behave identically in both modes.

## Test plan
All scenarios use the defaults, with `BP_GSHARE_EN` undefined unless stated.
- **Reset.**
  - Stimulus: release reset, `fetch_pc`=0x100.
  - Required: `pred_taken`=0, `pred_target`=0x104, both counts=0.
- **Training.**
  - Stimulus: one taken update at 0x100 → 0x200.
  - Required: counter goes to 2'b10; the next-cycle fetch of 0x100 gives `pred_taken`=1, `pred_target`=0x200, `branch_count`=1.
- **Saturation and hysteresis.**
  - Stimulus: three taken updates at 0x100, then one not-taken.
  - Required: `pred_taken` is still 1. After a second not-taken, `pred_taken`=0.
- **Aliasing.**
  - Setup: 0x100 trained taken to 0x200.
  - Stimulus: fetch 0x200 (same index, different tag).
  - Required: `pred_taken`=0, `pred_target`=0x204.
- **Misprediction accounting.**
  - Stimulus: update with `upd_pred_taken`=1 and `upd_pred_target`=0x200, but actual target 0x300, taken.
  - Required: `mispredict`=1 and `mispredict_count`=1. The BTB target becomes 0x300.
- **Gshare.**
  - Setup: `BP_GSHARE_EN` defined, GHR_BITS=6.
  - Stimulus: branch at 0x100 alternating taken/not-taken, each update carrying its fetch-time `pred_ghr`.
  - Required: after a warm-up of 8 resolves, zero further mispredicts over 16 resolves. The same pattern in bimodal mode gives ≥ 8 mispredicts.
